// File: rtl/dvp_frame_source_pkg.sv
// Shared constants for the DVP test-frame source: pattern codes, bar colours,
// default VGA timing, FSM state encoding and width helpers.
package dvp_frame_source_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_H_BLANK   = 288;
  localparam int DEF_VS_LINES  = 3;
  localparam int DEF_VBP_LINES = 17;
  localparam int DEF_VFP_LINES = 10;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } state_t;

  localparam logic [11:0] BAR_WHITE   = 12'hFFF;
  localparam logic [11:0] BAR_YELLOW  = 12'hFF0;
  localparam logic [11:0] BAR_CYAN    = 12'h0FF;
  localparam logic [11:0] BAR_GREEN   = 12'h0F0;
  localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
  localparam logic [11:0] BAR_RED     = 12'hF00;
  localparam logic [11:0] BAR_BLUE    = 12'h00F;
  localparam logic [11:0] BAR_BLACK   = 12'h000;

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Pixel coordinates keep at least 6 bits so bit 5 exists for gradient/checker.
  function automatic int pix_w(input int n);
    return ($clog2(n) < 6) ? 6 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dvp_pattern_pixel.sv
// Combinational test-pattern generator: pixel coordinate to 12-bit {R,G,B}.
module dvp_pattern_pixel
  import dvp_frame_source_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [1:0]    sel,
  input  logic [11:0]   solid,
  input  logic [7:0]    frame_cnt,
  output logic [11:0]   rgb
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar;
  logic       unused_bits;

  assign bar         = 3'(x / XW'(BAR_W));
  assign unused_bits = ^{y, frame_cnt};

  always_comb begin
    rgb = '0;
    case (pattern_t'(sel))
      PAT_BARS:  rgb = bar_colour(bar);
      PAT_GRAD:  rgb = {x[5:2], y[5:2], frame_cnt[3:0]};
      PAT_SOLID: rgb = solid;
      PAT_CHECK: rgb = (x[5] ^ y[5]) ? BAR_WHITE : BAR_BLACK;
      default:   rgb = '0;
    endcase
  end

endmodule

// File: rtl/dvp_frame_source.sv
// OV7670-style DVP transmitter emitting VGA-timed test frames as RGB444
// byte pairs on vsync/href/data, clocked by the pclk it drives downstream.
module dvp_frame_source
  import dvp_frame_source_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int H_BLANK   = DEF_H_BLANK,
  parameter int VS_LINES  = DEF_VS_LINES,
  parameter int VBP_LINES = DEF_VBP_LINES,
  parameter int VFP_LINES = DEF_VFP_LINES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int LINE_CLKS = 2 * H_ACTIVE + H_BLANK;
  localparam int MAX_LINES = max_int(max_int(V_ACTIVE, VS_LINES),
                                     max_int(VBP_LINES, VFP_LINES));
  localparam int CW = cnt_w(LINE_CLKS);
  localparam int LW = cnt_w(MAX_LINES);
  localparam int XW = pix_w(H_ACTIVE);
  localparam int YW = pix_w(V_ACTIVE);

  state_t         state, state_nxt;
  logic [CW-1:0]  col;
  logic [LW-1:0]  line;
  logic [1:0]     pat_sel;
  logic [11:0]    pat_rgb;
  logic [11:0]    rgb;
  int             lines_cur;
  logic           line_end, last_line, frame_end;
  logic           vsync_d, href_d, busy_d, done_d;
  logic [7:0]     data_d;

  assign line_end  = (col == CW'(LINE_CLKS - 1));
  assign last_line = (line == LW'(lines_cur - 1));
  assign frame_end = (state == ST_VFP) && line_end && last_line;

  always_comb begin
    lines_cur = 1;
    case (state)
      ST_VSYNC:  lines_cur = VS_LINES;
      ST_VBP:    lines_cur = VBP_LINES;
      ST_ACTIVE: lines_cur = V_ACTIVE;
      ST_VFP:    lines_cur = VFP_LINES;
      default:   lines_cur = 1;
    endcase
  end

  dvp_pattern_pixel #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_pixel (
    .x         (XW'(col >> 1)),
    .y         (YW'(line)),
    .sel       (pat_sel),
    .solid     (pat_rgb),
    .frame_cnt (frame_cnt),
    .rgb       (rgb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      col     <= '0;
      line    <= '0;
      pat_sel <= '0;
      pat_rgb <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE || line_end) col <= '0;
      else                              col <= col + 1'b1;
      if (state_nxt != state) line <= '0;
      else if (line_end)      line <= line + 1'b1;
      if (state_nxt == ST_VSYNC && state != ST_VSYNC) begin
        pat_sel <= pattern_sel;
        pat_rgb <= solid_rgb;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (enable) state_nxt = ST_VSYNC;
      ST_VSYNC:  if (line_end && last_line) state_nxt = ST_VBP;
      ST_VBP:    if (line_end && last_line) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (line_end && last_line) state_nxt = ST_VFP;
      ST_VFP:    if (frame_end) state_nxt = enable ? ST_VSYNC : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode the current position and are registered, so the pins
  // trail state/col by one clock; frame_done lands on the last VFP output clock.
  always_comb begin
    vsync_d = 1'b0;
    href_d  = 1'b0;
    data_d  = '0;
    busy_d  = (state != ST_IDLE);
    done_d  = frame_end;
    case (state)
      ST_VSYNC: vsync_d = 1'b1;
      ST_ACTIVE: begin
        if (col < CW'(2 * H_ACTIVE)) begin
          href_d = 1'b1;
          data_d = col[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vsync      <= vsync_d;
      href       <= href_d;
      data       <= data_d;
      busy       <= busy_d;
      frame_done <= done_d;
      if (done_d) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dvp_frame_source.sv
// Directed bench for dvp_frame_source with a byte scoreboard filled at frame start.
module tb_dvp_frame_source;

  localparam int HA    = 8;
  localparam int VA    = 4;
  localparam int HB    = 4;
  localparam int VS    = 1;
  localparam int VBP   = 1;
  localparam int VFP   = 1;
  localparam int LINE  = 2 * HA + HB;
  localparam int FRAME = (VS + VBP + VA + VFP) * LINE;

  logic        clk, rst_n, enable;
  logic [1:0]  pattern_sel;
  logic [11:0] solid_rgb;
  logic        vsync, href, busy, frame_done;
  logic [7:0]  data, frame_cnt;

  int          checks   = 0;
  int          failures = 0;
  int          mfc      = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  bar_bytes [16];

  dvp_frame_source #(
    .H_ACTIVE  (HA),
    .V_ACTIVE  (VA),
    .H_BLANK   (HB),
    .VS_LINES  (VS),
    .VBP_LINES (VBP),
    .VFP_LINES (VFP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .vsync       (vsync),
    .href        (href),
    .data        (data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int x, input int y, input logic [1:0] sel,
                                            input logic [11:0] solid, input int fc);
    logic [9:0]  xv;
    logic [8:0]  yv;
    logic [7:0]  fv;
    logic [11:0] bars [8];
    xv = 10'(x);
    yv = 9'(y);
    fv = 8'(fc);
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    case (sel)
      2'd0:    return bars[x / (HA / 8)];
      2'd1:    return {xv[5:2], yv[5:2], fv[3:0]};
      2'd2:    return solid;
      default: return (xv[5] ^ yv[5]) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic push_model(input logic [1:0] sel, input logic [11:0] solid, input int fc);
    logic [11:0] c;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) begin
        c = model_rgb(x, y, sel, solid, fc);
        exp_q.push_back({4'h0, c[11:8]});
        exp_q.push_back(c[7:0]);
      end
  endtask

  task automatic push_bars();
    for (int y = 0; y < VA; y++)
      for (int i = 0; i < 2 * HA; i++) exp_q.push_back(bar_bytes[i]);
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_outputs"}, 32'({vsync, href, data, busy, frame_done}), 32'd0);
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(mfc));
    end
  endtask

  task automatic start_frame(input logic pulse);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("start_latency", 32'({vsync, busy}), 32'd0);
    if (pulse) enable = 1'b0;
  endtask

  task automatic watch_frame(input int drop_at, input int chg_at,
                             input logic [1:0] chg_sel, input logic [11:0] chg_rgb);
    int ln, cl, vs_clks, href_clks, href_rises;
    logic prev_href, exp_href;
    logic [7:0] e;
    vs_clks = 0; href_clks = 0; href_rises = 0; prev_href = 1'b0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      ln = (c - 1) / LINE;
      cl = (c - 1) % LINE;
      exp_href = (ln >= VS + VBP) && (ln < VS + VBP + VA) && (cl < 2 * HA);
      check($sformatf("vsync c%0d", c), 32'(vsync), 32'(ln < VS));
      check($sformatf("href c%0d", c), 32'(href), 32'(exp_href));
      check($sformatf("busy c%0d", c), 32'(busy), 32'd1);
      check($sformatf("frame_done c%0d", c), 32'(frame_done), 32'(c == FRAME));
      check($sformatf("frame_cnt c%0d", c), 32'(frame_cnt), 32'((c == FRAME) ? mfc + 1 : mfc));
      if (href) begin
        check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("data line%0d col%0d", ln, cl), 32'(data), 32'(e));
        end
      end else begin
        check($sformatf("data_blank c%0d", c), 32'(data), 32'd0);
      end
      if (vsync) vs_clks++;
      if (href) href_clks++;
      if (href && !prev_href) href_rises++;
      prev_href = href;
      if (c == drop_at) enable = 1'b0;
      if (c == chg_at) begin
        pattern_sel = chg_sel;
        solid_rgb   = chg_rgb;
      end
    end
    mfc++;
    check("vsync_clks", 32'(vs_clks), 32'(VS * LINE));
    check("href_pulses", 32'(href_rises), 32'(VA));
    check("href_clks", 32'(href_clks), 32'(VA * 2 * HA));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bar_bytes = '{8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hF0,
                  8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00};
    rst_n       = 1'b0;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    solid_rgb   = 12'h000;

    // Reset state, then 50 idle clocks with enable low.
    repeat (3) @(negedge clk);
    check("reset_state", 32'({vsync, href, data, busy, frame_done, frame_cnt}), 32'd0);
    rst_n = 1'b1;
    idle_check(50, "idle_disabled");

    // One-clock enable pulse, colour bars, back to IDLE.
    pattern_sel = 2'd0;
    push_bars();
    start_frame(1'b1);
    watch_frame(-1, -1, 2'd0, 12'h000);
    idle_check(5, "after_bars");

    // Solid colour; mid-frame change only affects the next frame.
    pattern_sel = 2'd2;
    solid_rgb   = 12'hA5C;
    push_model(2'd2, 12'hA5C, mfc);
    start_frame(1'b1);
    watch_frame(-1, 70, 2'd2, 12'h123);
    idle_check(3, "after_solid1");
    push_model(2'd2, 12'h123, mfc);
    start_frame(1'b1);
    watch_frame(-1, -1, 2'd2, 12'h123);
    idle_check(3, "after_solid2");

    // Reset mid-ACTIVE aborts at once; nothing emitted until enable returns.
    start_frame(1'b1);
    repeat (45) @(negedge clk);
    check("pre_reset_href", 32'(href), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'({vsync, href, data, busy, frame_done, frame_cnt}), 32'd0);
    mfc = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(30, "post_reset");

    // Continuous run: gradient then checkerboard, enable dropped at clock 150.
    pattern_sel = 2'd1;
    push_model(2'd1, 12'h123, mfc);
    start_frame(1'b0);
    watch_frame(-1, 70, 2'd3, 12'h123);
    push_model(2'd3, 12'h123, mfc);
    watch_frame(10, -1, 2'd3, 12'h123);
    idle_check(5, "after_continuous");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
